// File: rtl/lc3b_types.sv
// Shared LC-3b memory-path types: line/word widths and the L1-to-L2 arbiter enums.
package lc3b_types;

  localparam int unsigned LC3B_ADDR_W = 16;
  localparam int unsigned LC3B_LINE_W = 128;

  typedef logic [LC3B_ADDR_W-1:0] lc3b_word;
  typedef logic [LC3B_LINE_W-1:0] lc3b_line;

  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY} lc3b_arb_state;
  typedef enum logic {ICACHE, DCACHE} lc3b_arb_client;

endpackage

// File: rtl/cache_arbiter_control.sv
// Arbiter FSM: picks the next L2 owner from IDLE, alternating on ties, and
// holds ownership until the L2 completion pulse.
module cache_arbiter_control
  import lc3b_types::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic          d_req,
  input  logic          l2_resp,
  output lc3b_arb_state state,
  output logic          grant_i_c,
  output logic          grant_d_c
);

  lc3b_arb_client last_grant;

  // Grants are only issued from IDLE, which also forces one idle cycle between transactions.
  always_comb begin
    grant_i_c = 1'b0;
    grant_d_c = 1'b0;
    if (state == IDLE) begin
      if (i_req && d_req) begin
        grant_d_c = (last_grant == ICACHE);
        grant_i_c = (last_grant == DCACHE);
      end else begin
        grant_i_c = i_req;
        grant_d_c = d_req;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= ICACHE;
    end else begin
      case (state)
        IDLE: begin
          if (grant_i_c) begin
            state      <= I_BUSY;
            last_grant <= ICACHE;
          end else if (grant_d_c) begin
            state      <= D_BUSY;
            last_grant <= DCACHE;
          end
        end
        I_BUSY, D_BUSY: begin
          if (l2_resp) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/cache_arbiter.sv
// Arbitrates the I-cache and D-cache miss ports onto one L2 port, latching the
// winning request at grant and steering the L2 completion back to its owner.
module cache_arbiter
  import lc3b_types::*;
#(
  parameter int unsigned ADDR_W = LC3B_ADDR_W,
  parameter int unsigned LINE_W = LC3B_LINE_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] icache_pmem_address,
  input  logic              icache_pmem_read,
  output logic [LINE_W-1:0] icache_pmem_rdata,
  output logic              icache_pmem_resp,
  input  logic [ADDR_W-1:0] dcache_pmem_address,
  input  logic              dcache_pmem_read,
  input  logic              dcache_pmem_write,
  input  logic [LINE_W-1:0] dcache_pmem_wdata,
  output logic [LINE_W-1:0] dcache_pmem_rdata,
  output logic              dcache_pmem_resp,
  output logic [ADDR_W-1:0] l2_address,
  output logic              l2_read,
  output logic              l2_write,
  output logic [LINE_W-1:0] l2_wdata,
  input  logic [LINE_W-1:0] l2_rdata,
  input  logic              l2_resp
);

  lc3b_arb_state state;
  logic          grant_i_c;
  logic          grant_d_c;

  cache_arbiter_control u_control (
    .clk       (clk),
    .reset     (reset),
    .i_req     (icache_pmem_read),
    .d_req     (dcache_pmem_read | dcache_pmem_write),
    .l2_resp   (l2_resp),
    .state     (state),
    .grant_i_c (grant_i_c),
    .grant_d_c (grant_d_c)
  );

  // Request latch: loaded only at grant, strobes dropped on the cycle after l2_resp.
  // A D-cache read+write is issued as a write.
  always_ff @(posedge clk) begin
    if (reset) begin
      l2_address <= '0;
      l2_wdata   <= '0;
      l2_read    <= 1'b0;
      l2_write   <= 1'b0;
    end else if (grant_i_c) begin
      l2_address <= icache_pmem_address;
      l2_read    <= 1'b1;
      l2_write   <= 1'b0;
    end else if (grant_d_c) begin
      l2_address <= dcache_pmem_address;
      l2_read    <= ~dcache_pmem_write;
      l2_write   <= dcache_pmem_write;
      if (dcache_pmem_write) l2_wdata <= dcache_pmem_wdata;
    end else if ((state != IDLE) && l2_resp) begin
      l2_read    <= 1'b0;
      l2_write   <= 1'b0;
    end
  end

  // Read data is broadcast; only the owning client sees the completion.
  assign icache_pmem_rdata = l2_rdata;
  assign dcache_pmem_rdata = l2_rdata;
  assign icache_pmem_resp  = (state == I_BUSY) && l2_resp;
  assign dcache_pmem_resp  = (state == D_BUSY) && l2_resp;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed plus randomized bench for cache_arbiter against a transaction-level
// ownership model of the two L1 clients and the L2 port.
module tb_cache_arbiter;
  import lc3b_types::*;

  localparam int unsigned AW = LC3B_ADDR_W;
  localparam int unsigned LW = LC3B_LINE_W;

  logic          clk;
  logic          reset;
  logic [AW-1:0] icache_pmem_address;
  logic          icache_pmem_read;
  logic [LW-1:0] icache_pmem_rdata;
  logic          icache_pmem_resp;
  logic [AW-1:0] dcache_pmem_address;
  logic          dcache_pmem_read;
  logic          dcache_pmem_write;
  logic [LW-1:0] dcache_pmem_wdata;
  logic [LW-1:0] dcache_pmem_rdata;
  logic          dcache_pmem_resp;
  logic [AW-1:0] l2_address;
  logic          l2_read;
  logic          l2_write;
  logic [LW-1:0] l2_wdata;
  logic [LW-1:0] l2_rdata;
  logic          l2_resp;

  cache_arbiter dut (
    .clk                 (clk),
    .reset               (reset),
    .icache_pmem_address (icache_pmem_address),
    .icache_pmem_read    (icache_pmem_read),
    .icache_pmem_rdata   (icache_pmem_rdata),
    .icache_pmem_resp    (icache_pmem_resp),
    .dcache_pmem_address (dcache_pmem_address),
    .dcache_pmem_read    (dcache_pmem_read),
    .dcache_pmem_write   (dcache_pmem_write),
    .dcache_pmem_wdata   (dcache_pmem_wdata),
    .dcache_pmem_rdata   (dcache_pmem_rdata),
    .dcache_pmem_resp    (dcache_pmem_resp),
    .l2_address          (l2_address),
    .l2_read             (l2_read),
    .l2_write            (l2_write),
    .l2_wdata            (l2_wdata),
    .l2_rdata            (l2_rdata),
    .l2_resp             (l2_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: who owns L2 (0 none, 1 I-cache, 2 D-cache) and what L2 should see.
  int            owner = 0;
  int            last  = 1;
  logic [AW-1:0] m_addr  = '0;
  logic          m_rd    = 1'b0;
  logic          m_wr    = 1'b0;
  logic [LW-1:0] m_wdata = '0;
  int            resp_log[$];
  logic          i_fired, d_fired;
  int            exp_order[6] = '{2, 1, 2, 1, 2, 1};

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    i_fired = (owner == 1) && l2_resp;
    d_fired = (owner == 2) && l2_resp;
    chk("l2_read", LW'(l2_read), LW'(m_rd));
    chk("l2_write", LW'(l2_write), LW'(m_wr));
    chk("icache_resp", LW'(icache_pmem_resp), LW'(i_fired));
    chk("dcache_resp", LW'(dcache_pmem_resp), LW'(d_fired));
    chk("icache_rdata", icache_pmem_rdata, l2_rdata);
    chk("dcache_rdata", dcache_pmem_rdata, l2_rdata);
    if (owner != 0) chk("l2_address", LW'(l2_address), LW'(m_addr));
    if (owner == 2 && m_wr) chk("l2_wdata", l2_wdata, m_wdata);
    if (icache_pmem_resp) resp_log.push_back(1);
    if (dcache_pmem_resp) resp_log.push_back(2);
  endtask

  task automatic model_update();
    logic i_req, d_req;
    int   win;
    i_req = icache_pmem_read;
    d_req = dcache_pmem_read | dcache_pmem_write;
    if (reset) begin
      owner = 0; last = 1; m_addr = '0; m_rd = 1'b0; m_wr = 1'b0; m_wdata = '0;
    end else if (owner != 0) begin
      if (l2_resp) begin
        owner = 0; m_rd = 1'b0; m_wr = 1'b0;
      end
    end else begin
      win = 0;
      if (i_req && d_req) win = (last == 1) ? 2 : 1;
      else if (i_req)     win = 1;
      else if (d_req)     win = 2;
      if (win == 1) begin
        owner = 1; last = 1; m_addr = icache_pmem_address; m_rd = 1'b1; m_wr = 1'b0;
      end else if (win == 2) begin
        owner = 2; last = 2; m_addr = dcache_pmem_address;
        m_wr = dcache_pmem_write; m_rd = ~dcache_pmem_write;
        if (dcache_pmem_write) m_wdata = dcache_pmem_wdata;
      end
    end
  endtask

  // One clock: check mid-cycle, advance the model at the edge, return just after it.
  task automatic step();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_update();
    #1;
  endtask

  function automatic logic [LW-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic i_pend, d_pend, d_wr;
    logic [AW-1:0] d_addr;
    reset = 1'b1;
    icache_pmem_address = '0; icache_pmem_read = 1'b0;
    dcache_pmem_address = '0; dcache_pmem_read = 1'b0; dcache_pmem_write = 1'b0;
    dcache_pmem_wdata = '0; l2_rdata = '0; l2_resp = 1'b0;
    #1;
    step(); step();
    reset = 1'b0;

    // Reset state
    chk("rst_l2_address", LW'(l2_address), LW'(0));
    chk("rst_l2_wdata", l2_wdata, LW'(0));
    chk("rst_l2_read", LW'(l2_read), LW'(0));
    chk("rst_l2_write", LW'(l2_write), LW'(0));

    // I-cache read alone, L2 answers in cycle 4
    resp_log.delete();
    icache_pmem_address = 16'h1230; icache_pmem_read = 1'b1;
    step();
    chk("t1_addr", LW'(l2_address), LW'(16'h1230));
    chk("t1_read", LW'(l2_read), LW'(1));
    step(); step(); step();
    l2_rdata = {16{8'hA5}}; l2_resp = 1'b1;
    chk("t1_rdata", icache_pmem_rdata, {16{8'hA5}});
    step();
    icache_pmem_read = 1'b0; l2_resp = 1'b0;
    step();
    chk("t1_resp_count", LW'(resp_log.size()), LW'(1));
    chk("t1_resp_who", LW'(resp_log.size() > 0 ? resp_log[0] : 0), LW'(1));

    // D-cache writeback, client wdata changes mid-transaction
    resp_log.delete();
    dcache_pmem_address = 16'h4000; dcache_pmem_write = 1'b1;
    dcache_pmem_wdata = 128'h0123456789ABCDEF0123456789ABCDEF;
    step();
    chk("t2_write", LW'(l2_write), LW'(1));
    chk("t2_addr", LW'(l2_address), LW'(16'h4000));
    dcache_pmem_wdata = '1; dcache_pmem_address = 16'h7777;
    step();
    chk("t2_wdata_held", l2_wdata, 128'h0123456789ABCDEF0123456789ABCDEF);
    l2_resp = 1'b1;
    step();
    dcache_pmem_write = 1'b0; l2_resp = 1'b0;
    step(); step();
    chk("t2_resp_count", LW'(resp_log.size()), LW'(1));
    chk("t2_resp_who", LW'(resp_log.size() > 0 ? resp_log[0] : 0), LW'(2));

    // Continuous contention from reset: strict D, I, D, I, D, I
    reset = 1'b1; step(); reset = 1'b0;
    resp_log.delete();
    icache_pmem_read = 1'b1; dcache_pmem_read = 1'b1;
    for (int c = 0; c < 200 && resp_log.size() < 6; c++) begin
      icache_pmem_address = AW'($urandom); dcache_pmem_address = AW'($urandom);
      l2_rdata = rand_line();
      l2_resp = (owner != 0) && (c % 3 == 2);
      step();
    end
    icache_pmem_read = 1'b0; dcache_pmem_read = 1'b0; l2_resp = 1'b0;
    step();
    chk("t3_resp_count", LW'(resp_log.size()), LW'(6));
    for (int k = 0; k < 6; k++)
      chk($sformatf("t3_order_%0d", k), LW'(k < resp_log.size() ? resp_log[k] : 0), LW'(exp_order[k]));

    // Reset during D_BUSY, late l2_resp ignored
    resp_log.delete();
    dcache_pmem_address = 16'h0BEE; dcache_pmem_read = 1'b1;
    step(); step();
    reset = 1'b1; dcache_pmem_read = 1'b0;
    step();
    reset = 1'b0;
    chk("t4_read_low", LW'(l2_read), LW'(0));
    step();
    l2_resp = 1'b1;
    step();
    l2_resp = 1'b0;
    step();
    chk("t4_no_resp", LW'(resp_log.size()), LW'(0));

    // Stray l2_resp in IDLE, then illegal D read+write issued as a write
    l2_resp = 1'b1;
    step();
    l2_resp = 1'b0;
    chk("t5_stray_ignored", LW'(resp_log.size()), LW'(0));
    dcache_pmem_address = 16'h2222; dcache_pmem_read = 1'b1; dcache_pmem_write = 1'b1;
    dcache_pmem_wdata = rand_line();
    step();
    chk("t5_rw_write", LW'(l2_write), LW'(1));
    chk("t5_rw_read", LW'(l2_read), LW'(0));
    l2_resp = 1'b1;
    step();
    dcache_pmem_read = 1'b0; dcache_pmem_write = 1'b0; l2_resp = 1'b0;
    step();
    chk("t5_resp_count", LW'(resp_log.size()), LW'(1));

    // Randomized clients and L2 latency, with occasional stray resp and reset
    i_pend = 1'b0; d_pend = 1'b0; d_wr = 1'b0; d_addr = '0;
    for (int c = 0; c < 800; c++) begin
      if (!i_pend && ($urandom % 4 == 0)) begin
        i_pend = 1'b1; icache_pmem_address = AW'($urandom);
      end
      if (!d_pend && ($urandom % 4 == 0)) begin
        d_pend = 1'b1; d_addr = AW'($urandom);
        case ($urandom % 3)
          0:       begin dcache_pmem_read = 1'b1; dcache_pmem_write = 1'b0; end
          1:       begin dcache_pmem_read = 1'b0; dcache_pmem_write = 1'b1; end
          default: begin dcache_pmem_read = 1'b1; dcache_pmem_write = 1'b1; end
        endcase
      end
      d_wr = d_pend;
      icache_pmem_read = i_pend;
      if (!d_wr) begin dcache_pmem_read = 1'b0; dcache_pmem_write = 1'b0; end
      dcache_pmem_address = ($urandom % 8 == 0) ? AW'($urandom) : d_addr;
      dcache_pmem_wdata = rand_line();
      l2_rdata = rand_line();
      reset = ($urandom % 150 == 0);
      l2_resp = reset ? 1'b0 : ((owner != 0) ? ($urandom % 3 == 0) : ($urandom % 12 == 0));
      step();
      if (i_fired) i_pend = 1'b0;
      if (d_fired) d_pend = 1'b0;
    end
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cache_arbiter.md
Name: cache_arbiter

Overview:
- Sits directly downstream of the cpu's split L1 caches: I-cache miss/fill port and D-cache miss/writeback port.
- Arbitrates both onto the single L2 cache port, one line-sized transaction at a time.
- Latches the winning request at grant and holds it stable to L2 until l2_resp.
- Routes the L2 response back to the granted client only.

Parameters:
- ADDR_W, 16, physical address width (lc3b_word).
- LINE_W, 128, cache line width in bits (lc3b_line).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- icache_pmem_address  in  ADDR_W  I-cache line address.
- icache_pmem_read  in  1  I-cache read request; held until icache_pmem_resp.
- icache_pmem_rdata  out  LINE_W  read line data returned to the I-cache.
- icache_pmem_resp  out  1  single-cycle completion pulse to the I-cache.
- dcache_pmem_address  in  ADDR_W  D-cache line address.
- dcache_pmem_read  in  1  D-cache read request.
- dcache_pmem_write  in  1  D-cache writeback request.
- dcache_pmem_wdata  in  LINE_W  writeback line data.
- dcache_pmem_rdata  out  LINE_W  read line data returned to the D-cache.
- dcache_pmem_resp  out  1  single-cycle completion pulse to the D-cache.
- l2_address  out  ADDR_W  latched address to L2.
- l2_read  out  1  read request to L2.
- l2_write  out  1  write request to L2.
- l2_wdata  out  LINE_W  latched write data to L2.
- l2_rdata  in  LINE_W  L2 read data, valid when l2_resp is high.
- l2_resp  in  1  L2 completion pulse.

Behaviour:
- FSM states: IDLE, I_BUSY, D_BUSY. Reset state is IDLE.
- Reset values: l2_read=0, l2_write=0, l2_address=0, l2_wdata=0, both resp outputs=0. Internal last_grant resets to ICACHE.
- IDLE, grant decision (taken at the clock edge):
  - If only the I-cache requests, go to I_BUSY.
  - If only the D-cache requests, go to D_BUSY.
  - If both request, grant the client not in last_grant. The first tie after reset therefore goes to the D-cache.
  - At grant: latch address; latch op (read/write); for D writes also latch wdata; update last_grant.
- I_BUSY / D_BUSY:
  - l2_address and l2_wdata are driven from the latch registers.
  - l2_read or l2_write is driven high from the latched op, continuously until l2_resp.
  - Request latency: a request first sampled in IDLE at edge t reaches the L2 outputs at cycle t+1.
- Response:
  - In a BUSY state with l2_resp=1, the granted client's resp is asserted combinationally in that same cycle.
  - l2_rdata is broadcast to both rdata outputs at all times; only the granted client sees resp.
  - Next state is IDLE; l2_read/l2_write deassert on the following cycle.
- Turnaround: at least one IDLE cycle between transactions, even when the other client is already waiting. This prevents re-granting a client that drops its request on its resp edge.
- The latched address and data are not updated while BUSY; client input changes mid-transaction are ignored.
- A client deasserting its request mid-transaction is illegal. The arbiter completes the L2 transaction anyway and still pulses resp.
- dcache read and write asserted together are illegal; the arbiter treats this as a write.
- l2_resp while in IDLE is ignored: no client resp, no state change.
- Reset mid-transaction: return to IDLE; L2 strobes are low in the next cycle. A late l2_resp after reset is ignored; last_grant returns to ICACHE.
- Fairness: under continuous contention, grants strictly alternate D, I, D, I, and so on.

Decomposition:
- Add to shared package lc3b_types:
  - typedef lc3b_line, logic [127:0].
  - enum lc3b_arb_state {IDLE, I_BUSY, D_BUSY}.
  - enum lc3b_arb_client {ICACHE, DCACHE}.
- One sub-module, cache_arbiter_control: FSM plus last_grant, producing grant and latch enables.
- Top level: latch registers and the output/response muxing.

Test Plan:
- Reset, then I-cache reads 0x1230 alone; L2 returns line 0xA5..A5 at cycle 4 -> l2_read high cycles 1-4, l2_address=0x1230; icache_pmem_resp high only in cycle 4 with rdata=0xA5..A5; dcache_pmem_resp stays 0.
- D-cache writes 0x4000, wdata=0x0123..CDEF -> l2_write=1, l2_address=0x4000, l2_wdata=0x0123..CDEF; client changes its wdata mid-transaction and l2_wdata stays unchanged; dcache_pmem_resp pulses once.
- Both clients request in the same cycle after reset -> D granted first; I granted after resp plus one IDLE cycle; a third tie is granted to D.
- Continuous contention over 6 transactions -> grant order D, I, D, I, D, I; no client is ever waiting more than one full transaction.
- Reset asserted during D_BUSY, with l2_resp arriving 2 cycles later -> next cycle is IDLE with strobes 0; the late l2_resp produces no client resp.
- Stray l2_resp in IDLE, and dcache read+write asserted together -> the stray resp is ignored; the illegal read+write is issued as l2_write=1, l2_read=0.
